input_run_sequencer: RTL

//   Sequences one compute run: on start_i, reads run_count_i words from input BRAM port 0.

---
 rtl/input_run_sequencer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/input_run_sequencer.sv
// ============================================================================
// input_run_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Sequences one compute run. An accepted start latches the run length N and
//   reads words 0..N-1 from input BRAM port 0. The words are streamed through
//   a 2-entry buffer to the core using a valid/ready handshake. The block then
//   counts the results the core hands back and pulses done_o once all N have
//   arrived.
//
// Parameters:
//   CNT_WIDTH   BRAM address width; a run may be up to 2**CNT_WIDTH words
//   DATA_WIDTH  data word width
//
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous, active-low reset
//   start_i         start pulse, only looked at while idle
//   run_count_i     number of words in the run, latched on an accepted start
//   addr0_o         input BRAM read address (equals the issue count)
//   ce0_o           input BRAM chip enable; one read issued per high cycle
//   q0_i            BRAM read data, valid the cycle after ce0_o
//   data_o          operand to the core (buffer head)
//   valid_o         data_o holds a real word
//   ready_i         core takes data_o when valid_o && ready_i
//   result_valid_i  core produced one result this cycle
//   busy_o          high from the cycle after start through the done cycle
//   done_o          one-cycle pulse when the run is complete
//   cycles_o        run length in cycles (only with RUN_SEQ_PERF_CNT_EN)
//
// Configuration:
//   RUN_SEQ_PERF_CNT_EN  when defined, cycles_o reports the number of cycles
//                        from the accepted start cycle through the done cycle
//                        inclusive. The count is final from the cycle after
//                        done_o and holds until the next start. When the
//                        macro is undefined cycles_o is tied to zero and the
//                        counter does not exist.
// ============================================================================
module input_run_sequencer #(
  parameter int CNT_WIDTH  = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [CNT_WIDTH:0]    run_count_i,
  output logic [CNT_WIDTH-1:0]  addr0_o,
  output logic                  ce0_o,
  input  logic [DATA_WIDTH-1:0] q0_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  result_valid_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           cycles_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH:0] CNT_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [CNT_WIDTH:0]    n_q, n_d;
  logic [CNT_WIDTH:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_WIDTH:0]    feed_cnt_q, feed_cnt_d;
  logic [CNT_WIDTH:0]    res_cnt_q, res_cnt_d;
  logic                  in_flight_q, in_flight_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic                  start_accept;
  logic                  push;
  logic                  pop;
  logic [2:0]            outstanding;
  logic                  count_result;

  assign start_accept = (state_q == ST_IDLE) && start_i;

  // A word lands in the buffer exactly one cycle after its read was issued.
  assign push = in_flight_q;
  assign pop  = valid_o && ready_i;

  // Words that will occupy the buffer after this edge if no new read is
  // issued: stored words plus the read in flight, minus the one leaving now.
  // pop implies occ_q != 0, so this never underflows.
  assign outstanding = 3'(occ_q) + 3'(in_flight_q) - 3'(pop);

  // A new read is only issued while the buffer can still absorb it, which is
  // what bounds occupancy at two without ever dropping a returning word.
  assign ce0_o   = (state_q == ST_RUN) && (issue_cnt_q < n_q) && (outstanding < 3'd2);
  assign addr0_o = issue_cnt_q[CNT_WIDTH-1:0];

  // Results are only meaningful while a run is active and saturate at N.
  assign count_result = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                        result_valid_i && (res_cnt_q < n_q);

  assign data_o  = rd_ptr_q ? buf1_q : buf0_q;
  assign valid_o = (occ_q != 2'd0);
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    issue_cnt_d = issue_cnt_q;
    feed_cnt_d  = feed_cnt_q;
    res_cnt_d   = res_cnt_q;
    in_flight_d = ce0_o;
    occ_d       = occ_q + 2'(push) - 2'(pop);
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;

    if (ce0_o) begin
      issue_cnt_d = issue_cnt_q + CNT_ONE;
    end

    // Returning read data goes to the tail; push and pop in the same cycle
    // touch different entries because occupancy is at most two.
    if (push) begin
      if (wr_ptr_q) begin
        buf1_d = q0_i;
      end else begin
        buf0_d = q0_i;
      end
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      feed_cnt_d = feed_cnt_q + CNT_ONE;
    end

    if (count_result) begin
      res_cnt_d = res_cnt_q + CNT_ONE;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_accept) begin
          n_d         = run_count_i;
          issue_cnt_d = '0;
          feed_cnt_d  = '0;
          res_cnt_d   = '0;
          rd_ptr_d    = 1'b0;
          wr_ptr_d    = 1'b0;
          // An empty run touches no memory and completes straight away.
          state_d     = (run_count_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Every word has been handed over; no read can still be in flight.
        if (feed_cnt_q == n_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_cnt_q == n_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers; reset discards any buffered or in-flight data immediately.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      issue_cnt_q <= '0;
      feed_cnt_q  <= '0;
      res_cnt_q   <= '0;
      in_flight_q <= 1'b0;
      occ_q       <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      issue_cnt_q <= issue_cnt_d;
      feed_cnt_q  <= feed_cnt_d;
      res_cnt_q   <= res_cnt_d;
      in_flight_q <= in_flight_d;
      occ_q       <= occ_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

`ifdef RUN_SEQ_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Run cycle counter. The start cycle itself counts as the first cycle, and
  // every cycle spent in RUN, DRAIN and DONE adds one, so the value seen from
  // the cycle after done_o covers start through done inclusive. Idle cycles
  // leave it untouched.
  // --------------------------------------------------------------------------
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (start_accept) begin
      cycles_d = 32'd1;
    end else if (state_q != ST_IDLE) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = 32'd0;
`endif

endmodule
